// File: rtl/osd_text_reader.sv
// OSD text overlay: scans the character RAM in raster order, fetches glyph rows
// from the font ROM and composites the text window onto the video stream.
module osd_text_reader #(
    parameter int COLS = 32,
    parameter int ROWS = 16,
    parameter int X0   = 16,
    parameter int Y0   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        osd_enable,
    input  logic        vid_de,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic [23:0] vid_rgb,
    output logic [10:0] ram_rd_addr,
    input  logic [7:0]  ram_rd_data,
    output logic [9:0]  font_addr,
    input  logic [7:0]  font_data,
    output logic        out_de,
    output logic        out_hs,
    output logic        out_vs,
    output logic [23:0] out_rgb
);

    localparam int XEND = X0 + 8 * COLS;
    localparam int YEND = Y0 + 8 * ROWS;

    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic        de_prev;
    logic        vs_prev;

    logic        vs_rise;
    logic        de_fall;
    logic        in_win;
    logic [9:0]  y_cur;
    logic [10:0] dx;
    logic [9:0]  dy;
    logic [10:0] addr_calc;

    // Stage k+1 of the sideband lives in bit/element k of each shift register.
    logic [3:0]        v_sr;
    logic [3:0]        en_sr;
    logic [3:0]        de_sr;
    logic [3:0]        hs_sr;
    logic [3:0]        vs_sr;
    logic [3:0][2:0]   bsel_sr;
    logic [1:0][2:0]   grow_sr;
    logic [3:0][23:0]  rgb_sr;
    logic              inv_s3;
    logic              inv_s4;

    logic        pix;
    logic [23:0] dim;

    always_comb begin
        vs_rise   = vid_vs & ~vs_prev;
        de_fall   = de_prev & ~vid_de;
        // A pixel coinciding with the vsync rise already belongs to line 0.
        y_cur     = vs_rise ? '0 : y_cnt;
        dx        = x_cnt - 11'(X0);
        dy        = y_cur - 10'(Y0);
        in_win    = vid_de
                  && ({1'b0, x_cnt} >= 12'(X0)) && ({1'b0, x_cnt} < 12'(XEND))
                  && ({1'b0, y_cur} >= 11'(Y0)) && ({1'b0, y_cur} < 11'(YEND));
        addr_calc = 11'(dy[9:3]) * 11'(COLS) + 11'(dx[10:3]);
    end

    always_comb begin
        pix = font_data[3'd7 - bsel_sr[3]] ^ inv_s4;
        dim = {1'b0, rgb_sr[3][23:17], 1'b0, rgb_sr[3][15:9], 1'b0, rgb_sr[3][7:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            de_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            x_cnt   <= vid_de ? x_cnt + 11'd1 : '0;
            de_prev <= vid_de;
            vs_prev <= vid_vs;
            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall)
                y_cnt <= y_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_sr        <= '0;
            en_sr       <= '0;
            de_sr       <= '0;
            hs_sr       <= '0;
            vs_sr       <= '0;
            bsel_sr     <= '0;
            grow_sr     <= '0;
            rgb_sr      <= '0;
            inv_s3      <= 1'b0;
            inv_s4      <= 1'b0;
            ram_rd_addr <= '0;
            font_addr   <= '0;
            out_de      <= 1'b0;
            out_hs      <= 1'b0;
            out_vs      <= 1'b0;
            out_rgb     <= '0;
        end else begin
            v_sr    <= {v_sr[2:0], in_win};
            en_sr   <= {en_sr[2:0], osd_enable};
            de_sr   <= {de_sr[2:0], vid_de};
            hs_sr   <= {hs_sr[2:0], vid_hs};
            vs_sr   <= {vs_sr[2:0], vid_vs};
            bsel_sr <= {bsel_sr[2:0], dx[2:0]};
            grow_sr <= {grow_sr[0], dy[2:0]};
            rgb_sr  <= {rgb_sr[2:0], vid_rgb};

            if (in_win)
                ram_rd_addr <= addr_calc;
            if (v_sr[1]) begin
                font_addr <= {ram_rd_data[6:0], grow_sr[1]};
                inv_s3    <= ram_rd_data[7];
            end
            inv_s4 <= inv_s3;

            out_de  <= de_sr[3];
            out_hs  <= hs_sr[3];
            out_vs  <= vs_sr[3];
            out_rgb <= (v_sr[3] & en_sr[3]) ? (pix ? '1 : dim) : rgb_sr[3];
        end
    end

endmodule

// File: tb/tb_osd_text_reader.sv
// Directed bench for osd_text_reader with behavioural character RAM and font ROM.
module tb_osd_text_reader;

    localparam int HACT = 280;
    localparam int NEVER = 99999;
    localparam logic [23:0] WH = 24'hFFFFFF;
    localparam logic [23:0] DM = 24'h404040;
    localparam logic [23:0] GR = 24'h808080;

    logic        clk = 1'b0;
    logic        reset;
    logic        osd_enable;
    logic        vid_de, vid_hs, vid_vs;
    logic [23:0] vid_rgb;
    logic [10:0] ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic [9:0]  font_addr;
    logic [7:0]  font_data;
    logic        out_de, out_hs, out_vs;
    logic [23:0] out_rgb;

    logic [7:0] ram  [0:2047];
    logic [7:0] font [0:1023];
    logic [7:0] font_a [0:7];

    int errors = 0;
    int checks = 0;

    logic [23:0] r_rgb [0:7];
    logic        r_de  [0:7];
    logic        r_hs  [0:7];
    logic        r_vs  [0:7];
    int          r_x   [0:7];
    int          sc = 0;
    int          rst_age = 0;

    logic [23:0] cap  [0:HACT-1];
    logic        capv [0:HACT-1];

    always #5 clk = ~clk;

    osd_text_reader #(.COLS(32), .ROWS(16), .X0(16), .Y0(16)) dut (
        .clk(clk), .reset(reset), .osd_enable(osd_enable),
        .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_rgb(vid_rgb),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .font_addr(font_addr), .font_data(font_data),
        .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .out_rgb(out_rgb)
    );

    always @(posedge clk) begin
        ram_rd_data <= ram[ram_rd_addr];
        font_data   <= font[font_addr];
    end

    function automatic logic [23:0] pat(input int x);
        return {x[7:0], 8'(x * 7), 8'(255 - x)};
    endfunction

    function automatic logic [23:0] glyph_px(input logic [7:0] g, input int i);
        return g[7 - i] ? WH : DM;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_px(input string tag, input int x, input logic [23:0] exp);
        chk($sformatf("%s x=%0d", tag, x), capv[x] ? cap[x] : 24'hxxxxxx, exp);
    endtask

    task automatic step(input logic de, input logic hs, input logic vs, input logic en,
                        input logic [23:0] rgb, input int x);
        int k;
        vid_de = de; vid_hs = hs; vid_vs = vs; osd_enable = en; vid_rgb = rgb;
        @(posedge clk);
        #1;
        r_rgb[sc % 8] = rgb; r_de[sc % 8] = de; r_hs[sc % 8] = hs; r_vs[sc % 8] = vs;
        r_x[sc % 8] = de ? x : -1;
        if (reset) rst_age = 0; else rst_age++;
        k = (sc + 4) % 8;
        if (reset) begin
            checks++;
            assert ({out_de, out_hs, out_vs, out_rgb, ram_rd_addr, font_addr} === 48'd0) else begin
                errors++;
                $error("FAIL reset_state: observed de%b hs%b vs%b rgb%h ra%h fa%h expected all 0",
                       out_de, out_hs, out_vs, out_rgb, ram_rd_addr, font_addr);
            end
        end else if (rst_age >= 5) begin
            checks++;
            assert ({out_de, out_hs, out_vs} === {r_de[k], r_hs[k], r_vs[k]}) else begin
                errors++;
                $error("FAIL timing step=%0d: observed %b%b%b expected %b%b%b",
                       sc, out_de, out_hs, out_vs, r_de[k], r_hs[k], r_vs[k]);
            end
            if (r_x[k] >= 0) begin
                cap[r_x[k]]  = out_rgb;
                capv[r_x[k]] = 1'b1;
            end
        end
        sc++;
    endtask

    task automatic line(input int len, input logic [23:0] rgb, input bit use_pat,
                        input int en_from, input int rst_at);
        for (int i = 0; i < HACT; i++) capv[i] = 1'b0;
        for (int x = 0; x < len; x++) begin
            reset = (x >= rst_at) && (x < rst_at + 3);
            step(1'b1, 1'b0, 1'b0, x >= en_from, use_pat ? pat(x) : rgb, x);
        end
        reset = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, '0, -1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
    endtask

    task automatic short_lines(input int n);
        repeat (n) line(2, GR, 1'b0, NEVER, NEVER);
    endtask

    task automatic vsync();
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, '0, -1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
    endtask

    initial begin
        logic [23:0] exp_a  [0:7];
        logic [23:0] exp_ai [0:7];
        logic [23:0] exp_t  [0:7];
        exp_a  = '{DM, DM, DM, WH, WH, DM, DM, DM};
        exp_ai = '{WH, WH, WH, DM, DM, WH, WH, WH};
        exp_t  = '{GR, GR, GR, GR, WH, DM, DM, DM};
        font_a = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
        for (int i = 0; i < 2048; i++) ram[i] = 8'h20;
        for (int i = 0; i < 1024; i++) font[i] = 8'h00;
        for (int r = 0; r < 8; r++) font[{7'h41, 3'(r)}] = font_a[r];

        reset = 1'b1;
        vid_de = 1'b0; vid_hs = 1'b0; vid_vs = 1'b0; osd_enable = 1'b0; vid_rgb = '0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
        reset = 1'b0;
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, '0, -1);

        // Overlay disabled: pure passthrough
        ram[0] = 8'h41;
        vsync();
        line(HACT, '0, 1'b1, NEVER, NEVER);
        for (int x = 0; x < HACT; x++) chk_px("pass_line0", x, pat(x));
        short_lines(15);
        line(HACT, GR, 1'b0, NEVER, NEVER);
        for (int x = 12; x < 28; x++) chk_px("pass_off_win", x, GR);

        // Glyph 'A' at cell 0 and at the last cell
        ram[511] = 8'h41;
        vsync();
        short_lines(16);
        line(HACT, GR, 1'b0, 0, NEVER);
        chk_px("a_left_edge", 15, GR);
        for (int i = 0; i < 8; i++) chk_px("a_row0", 16 + i, exp_a[i]);
        chk_px("space_cell1", 24, DM);
        chk_px("space_cell31", 271, DM);
        chk_px("right_edge", 272, GR);
        short_lines(119);
        for (int r = 0; r < 8; r++) begin
            line(HACT, GR, 1'b0, 0, NEVER);
            chk_px($sformatf("last_pre r%0d", r), 263, DM);
            for (int i = 0; i < 8; i++)
                chk_px($sformatf("last_cell r%0d", r), 264 + i, glyph_px(font_a[r], i));
            chk_px($sformatf("last_post r%0d", r), 272, GR);
        end
        line(HACT, GR, 1'b0, 0, NEVER);
        chk_px("below_window", 264, GR);
        chk_px("below_window", 271, GR);

        // Inverse glyph
        ram[0] = 8'hC1;
        vsync();
        short_lines(16);
        line(HACT, GR, 1'b0, 0, NEVER);
        for (int i = 0; i < 8; i++) chk_px("inv_row0", 16 + i, exp_ai[i]);

        // Enable toggled at x = 20
        ram[0] = 8'h41;
        vsync();
        short_lines(16);
        line(HACT, GR, 1'b0, 20, NEVER);
        chk_px("toggle_pre", 15, GR);
        for (int i = 0; i < 8; i++) chk_px("toggle", 16 + i, exp_t[i]);
        chk_px("toggle_after", 30, DM);

        // Reset mid-line, then recovery on the next frame
        vsync();
        short_lines(16);
        line(HACT, '0, 1'b1, 0, 40);
        for (int x = 50; x < HACT; x++) chk_px("post_reset_pass", x, pat(x));
        short_lines(3);
        vsync();
        short_lines(16);
        line(HACT, GR, 1'b0, 0, NEVER);
        for (int i = 0; i < 8; i++) chk_px("recovered_row0", 16 + i, exp_a[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/osd_text_reader.md
# osd_text_reader

Read-side counterpart of the OSD string writer: scans the 2048×8 OSD character RAM in raster order, fetches 8×8 glyph rows from the font ROM and overlays the text window on the incoming video stream. It sits in the video path after the core's video output and before the scaler/Analogizer output stage. The character writer fills the RAM through the other RAM port; this block only reads it.

## Interface
- COLS, 32: text columns (8 px each).
- ROWS, 16: text rows (8 lines each); COLS*ROWS ≤ 2048.
- X0, 16: window left edge, in active pixels.
- Y0, 16: window top edge, in active lines.
- clk  in  1  pixel clock; one clock, every cycle is one pixel slot.
- reset  in  1  asynchronous, active-high.
- osd_enable  in  1  overlay on/off; sampled per pixel.
- vid_de / vid_hs / vid_vs  in  1 each  input video timing, active-high.
- vid_rgb  in  24  input pixel {R,G,B}.
- ram_rd_addr  out  11  character RAM read address.
- ram_rd_data  in  8  character code; registered RAM, valid 1 cycle after address.
- font_addr  out  10  {char[6:0], glyph_row[2:0]}.
- font_data  in  8  glyph row, MSB = leftmost pixel; registered ROM, 1 cycle latency.
- out_de / out_hs / out_vs  out  1 each  timing delayed to match pixels.
- out_rgb  out  24  composited pixel.

## Operation
- Position counters x (11 b), y (10 b):
  - x = 0 while vid_de low; +1 each cycle vid_de high.
  - y cleared on vid_vs rising edge; +1 on each vid_de falling edge.
- In-window: X0 ≤ x < X0+8*COLS and Y0 ≤ y < Y0+8*ROWS and vid_de high.
- col = (x−X0)>>3, row = (y−Y0)>>3, addr = row*COLS+col truncated to 11 b. Outside the window the address holds its last value.
- 5-stage pipeline; sideband per stage: valid, bit_sel = (x−X0)[2:0], glyph_row = (y−Y0)[2:0], de/hs/vs, rgb.
  - S1: register ram_rd_addr.
  - S2: RAM data returns.
  - S3: register font_addr = {ram_rd_data[6:0], glyph_row}; latch inverse = ram_rd_data[7].
  - S4: ROM data returns.
  - S5: pix = font_data[7−bit_sel] XOR inverse; register outputs.
- Compositing at S5:
  - valid & osd_enable & pix → 24'hFFFFFF.
  - valid & osd_enable & !pix → each channel of rgb shifted right by 1 (dim).
  - Otherwise → rgb passed unchanged.
- osd_enable is sampled with the pixel at S0 and carried through the pipeline. Toggling it never tears a pixel.
- There is no handshake with the writer. A character updated mid-frame takes effect at the first fetch after the write.

## Timing
- Latency: out_* at cycle n+5 corresponds to the input at cycle n, for all pixels including blanking.
- Throughput: 1 pixel per clock, no stalls.
- Reset (asynchronous) clears all outputs and pipeline registers:
  - out_de, out_hs, out_vs = 0; out_rgb = 0.
  - ram_rd_addr = 0; font_addr = 0.
  - x = 0, y = 0; all valid bits = 0.
- Reset mid-frame: output is video passthrough with correct timing. The vertical position may be wrong until the next vid_vs rising edge, which realigns y.
- Boundaries:
  - Last column/row (x = X0+8*COLS−1) is drawn; the next pixel is passthrough.
  - A window extending past the active area is clipped by vid_de.
  - A line shorter than the window leaves no state behind.
- vid_vs rise with vid_de high in the same cycle: y is cleared and the pixel uses y = 0.

## Test plan
- Reset then 640×480 timing, osd_enable = 0 → out_rgb == vid_rgb delayed 5 cycles; de/hs/vs delayed 5; RAM contents irrelevant.
- RAM[0] = 0x41, font 'A' row 0 = 8'h18, osd_enable = 1 → line 16, x 16..23 output dim, dim, dim, FFFFFF, FFFFFF, dim, dim, dim for input rgb 0x808080 (dim = 0x404040).
- RAM[0] = 0xC1 (inverse 'A') → same pixels with FFFFFF and dim swapped.
- RAM[COLS*ROWS−1] = 0x41 → glyph drawn at x 264..271, lines 136..143; pixel x = 272 and line 144 are passthrough.
- Assert reset for 3 cycles mid-line → all outputs 0 during reset; passthrough after; correct overlay from the frame following the next vid_vs rise.
- Toggle osd_enable on the pixel at x = 20 of a window line → outputs at x ≥ 20 are composited and x < 20 passthrough, aligned after 5 cycles of latency.
